// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, launch payload and
// bit-timing defaults.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 217;
  localparam int unsigned TIMEOUT_BITS     = 12;
  localparam int unsigned TIMEOUT_CLKS_DEF = TIMEOUT_BITS * CLKS_PER_BIT_DEF;
  localparam int unsigned WAIT_CNT_MIN_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_e;

  // Byte handed to the transmitter together with its launch strobe.
  typedef struct packed {
    logic       dv;
    logic [7:0] data;
  } tx_cmd_t;

  // Completion budget for a frame: a 10-bit frame plus two bit times of slack.
  function automatic int unsigned timeout_for(input int unsigned clks_per_bit);
    return TIMEOUT_BITS * clks_per_bit;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after the pointer,
// wrapping from N-1 back to 0.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  logic [W-1:0] cand;

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = W'((32'(i_ptr) + i) % N);
      if (!o_any && i_req[cand]) begin
        o_any = 1'b1;
        o_idx = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters using round-robin
// arbitration, with a completion timeout guarding against a stuck transmitter.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned TIMEOUT_CLKS = timeout_for(CLKS_PER_BIT),
  localparam int unsigned ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_byte,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic                 o_tx_dv,
  output logic [7:0]           o_tx_byte,
  input  logic                 i_tx_active,
  input  logic                 i_tx_done,
  output logic [ID_W-1:0]      o_grant_id,
  output logic                 o_busy,
  output logic                 o_timeout
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT_CLKS);
  localparam int unsigned CNT_W = (TO_W > WAIT_CNT_MIN_W) ? TO_W : WAIT_CNT_MIN_W;

  arb_state_e           state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  tx_cmd_t              tx_q, tx_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;

  logic [ID_W-1:0]      pick_idx;
  logic                 pick_any;
  logic [7:0]           req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_bytes[g] = i_req_byte[8*g +: 8];
  end

  rr_pick #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_rr_pick (
    .i_req (i_req_valid),
    .i_ptr (rr_ptr_q),
    .o_idx (pick_idx),
    .o_any (pick_any)
  );

  // Next-state and registered-output logic; outputs are computed one cycle ahead.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    tx_d.dv   = 1'b0;
    tx_d.data = tx_q.data;
    ready_d   = '0;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any && !i_tx_active) begin
          state_d   = ST_LAUNCH;
          grant_d   = pick_idx;
          tx_d.data = req_bytes[pick_idx];
        end
      end
      ST_LAUNCH: begin
        tx_d.dv          = 1'b1;
        ready_d[grant_q] = 1'b1;
        rr_ptr_d         = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
        cnt_d            = '0;
        state_d          = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // A completion landing on the terminal count wins over the timeout.
        if (i_tx_done) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CLKS - 1)) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      tx_q      <= '0;
      ready_q   <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_req_ready = ready_q;
  assign o_tx_dv     = tx_q.dv;
  assign o_tx_byte   = tx_q.data;
  assign o_grant_id  = grant_q;
  assign o_busy      = busy_q;
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural transmitter that reports each
// completed frame's byte.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int CPB   = 217;
  localparam int TO    = 4000;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_byte = '0;
  logic [3:0]  req_ready;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout;
  logic        dut_active;
  logic        dut_done;

  logic        mdl_active = 1'b0;
  logic        mdl_done = 1'b0;
  int          mdl_cnt = 0;
  logic [7:0]  mdl_shift = '0;
  logic        suppress_done = 1'b0;
  logic        manual = 1'b0;
  logic        man_active = 1'b0;
  logic        man_done = 1'b0;
  logic [3:0]  sticky = '0;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ready_cnt [4] = '{0, 0, 0, 0};
  int          dv_cnt = 0;
  int          to_cnt = 0;
  int          dv_cyc = 0;
  int          to_cyc = 0;
  logic        to_busy = 1'b0;
  logic [1:0]  grant_q [$];
  logic [7:0]  rx_q [$];

  assign dut_active = manual ? man_active : mdl_active;
  assign dut_done   = manual ? man_done : mdl_done;

  uart_tx_arbiter #(
    .NUM_REQ      (NREQ),
    .CLKS_PER_BIT (CPB),
    .TIMEOUT_CLKS (TO)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_byte  (req_byte),
    .o_req_ready (req_ready),
    .o_tx_dv     (tx_dv),
    .o_tx_byte   (tx_byte),
    .i_tx_active (dut_active),
    .i_tx_done   (dut_done),
    .o_grant_id  (grant_id),
    .o_busy      (busy),
    .o_timeout   (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: one frame of FRAME clocks per launch, not affected by rst_n.
  always @(posedge clk) begin
    mdl_done <= 1'b0;
    if (!mdl_active) begin
      if (!manual && tx_dv) begin
        mdl_active <= 1'b1;
        mdl_cnt    <= 0;
        mdl_shift  <= tx_byte;
      end
    end else if (mdl_cnt == FRAME - 1) begin
      mdl_active <= 1'b0;
      if (!suppress_done) begin
        mdl_done <= 1'b1;
        rx_q.push_back(mdl_shift);
      end
    end else begin
      mdl_cnt <= mdl_cnt + 1;
    end
  end

  // Event recorder sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (tx_dv) begin
      dv_cnt = dv_cnt + 1;
      dv_cyc = cyc;
      grant_q.push_back(grant_id);
    end
    for (int k = 0; k < 4; k++) if (req_ready[k]) ready_cnt[k] = ready_cnt[k] + 1;
    if (timeout) begin
      to_cnt  = to_cnt + 1;
      to_cyc  = cyc;
      to_busy = busy;
    end
  end

  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 4; k++) if (req_ready[k] && !sticky[k]) req_valid[k] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_quiet(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (req_valid == 4'b0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks += 6;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (tx_dv !== 1'b0) begin errors++; $display("FAIL reset_dv got %b exp 0", tx_dv); end
    if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_byte got %h exp 00", tx_byte); end
    if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d exp 0", grant_id); end
    if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int base_rx = rx_q.size();
    int base_rdy = ready_cnt[0];
    int base_dv = dv_cnt;
    bit ok;
    req_byte[7:0] = 8'h3F;
    req_valid = 4'b0001;
    tick();
    checks += 4;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_launch_busy got %b exp 1", busy); end
    if (tx_dv !== 1'b0) begin errors++; $display("FAIL single_early_dv got %b exp 0", tx_dv); end
    if (tx_byte !== 8'h3F) begin errors++; $display("FAIL single_byte got %h exp 3f", tx_byte); end
    if (grant_id !== 2'd0) begin errors++; $display("FAIL single_grant got %0d exp 0", grant_id); end
    tick();
    checks += 2;
    if (tx_dv !== 1'b1) begin errors++; $display("FAIL single_dv_latency got %b exp 1", tx_dv); end
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
    tick();
    checks += 2;
    if (tx_dv !== 1'b0) begin errors++; $display("FAIL single_dv_width got %b exp 0", tx_dv); end
    if (req_ready !== 4'b0) begin errors++; $display("FAIL single_ready_width got %b exp 0000", req_ready); end
    wait_quiet(FRAME + 50, ok);
    checks += 4;
    if (!ok) begin errors++; $display("FAIL single_wait got busy %b exp idle", busy); end
    if (rx_q.size() != base_rx + 1 || rx_q[rx_q.size()-1] !== 8'h3F)
      begin errors++; $display("FAIL single_rx got %0d frames exp one 3f", rx_q.size() - base_rx); end
    if (ready_cnt[0] - base_rdy != 1)
      begin errors++; $display("FAIL single_ready_cnt got %0d exp 1", ready_cnt[0] - base_rdy); end
    if (dv_cnt - base_dv != 1) begin errors++; $display("FAIL single_dv_cnt got %0d exp 1", dv_cnt - base_dv); end
  endtask

  task automatic test_all_four();
    logic [7:0] exp_b [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    int base_rx, base_g;
    int base_rdy [4];
    bit ok;
    do_reset();
    base_rx = rx_q.size();
    base_g  = grant_q.size();
    for (int k = 0; k < 4; k++) base_rdy[k] = ready_cnt[k];
    req_byte  = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    req_valid = 4'hF;
    wait_quiet(4 * (FRAME + 20) + 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL all4_wait got valid %b exp 0000", req_valid); end
    checks++;
    if (rx_q.size() != base_rx + 4)
      begin errors++; $display("FAIL all4_frames got %0d exp 4", rx_q.size() - base_rx); end
    else for (int k = 0; k < 4; k++) begin
      checks++;
      if (rx_q[base_rx+k] !== exp_b[k])
        begin errors++; $display("FAIL all4_rx%0d got %h exp %h", k, rx_q[base_rx+k], exp_b[k]); end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ready_cnt[k] - base_rdy[k] != 1)
        begin errors++; $display("FAIL all4_ready%0d got %0d exp 1", k, ready_cnt[k] - base_rdy[k]); end
    end
    if (grant_q.size() == base_g + 4) for (int k = 0; k < 4; k++) begin
      checks++;
      if (grant_q[base_g+k] !== 2'(k))
        begin errors++; $display("FAIL all4_grant%0d got %0d exp %0d", k, grant_q[base_g+k], k); end
    end
  endtask

  task automatic test_two_sticky();
    logic [1:0] exp_g [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
    logic [7:0] exp_b [4] = '{8'h11, 8'h33, 8'h11, 8'h33};
    int base_rx, base_g, base_dv, base1, base3;
    bit ok;
    do_reset();
    base_rx = rx_q.size();
    base_g  = grant_q.size();
    base_dv = dv_cnt;
    base1   = ready_cnt[1];
    base3   = ready_cnt[3];
    req_byte  = {8'h44, 8'h33, 8'h22, 8'h11};
    sticky    = 4'b0101;
    req_valid = 4'b0101;
    for (int i = 0; i < 4 * (FRAME + 20) + 100; i++) begin
      tick();
      if (dv_cnt - base_dv >= 4) break;
    end
    sticky    = 4'b0;
    req_valid = 4'b0;
    wait_quiet(FRAME + 50, ok);
    checks += 2;
    if (!ok || grant_q.size() != base_g + 4)
      begin errors++; $display("FAIL sticky_count got %0d grants exp 4", grant_q.size() - base_g); end
    if (ready_cnt[1] != base1 || ready_cnt[3] != base3)
      begin errors++; $display("FAIL sticky_idle_ready got %0d/%0d exp 0/0", ready_cnt[1]-base1, ready_cnt[3]-base3); end
    if (grant_q.size() >= base_g + 4 && rx_q.size() >= base_rx + 4) for (int k = 0; k < 4; k++) begin
      checks += 2;
      if (grant_q[base_g+k] !== exp_g[k])
        begin errors++; $display("FAIL sticky_grant%0d got %0d exp %0d", k, grant_q[base_g+k], exp_g[k]); end
      if (rx_q[base_rx+k] !== exp_b[k])
        begin errors++; $display("FAIL sticky_rx%0d got %h exp %h", k, rx_q[base_rx+k], exp_b[k]); end
    end
  endtask

  task automatic test_timeout();
    int base_to = to_cnt;
    int base_dv = dv_cnt;
    int base_rx = rx_q.size();
    suppress_done  = 1'b1;
    req_byte[31:24] = 8'h5A;
    req_valid      = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dv_cnt > base_dv) break;
    end
    repeat (1000) tick();
    checks += 2;
    if (tx_byte !== 8'h5A) begin errors++; $display("FAIL to_byte_hold got %h exp 5a", tx_byte); end
    if (busy !== 1'b1) begin errors++; $display("FAIL to_busy_wait got %b exp 1", busy); end
    for (int i = 0; i < TO; i++) begin
      tick();
      if (to_cnt > base_to) break;
    end
    repeat (3) tick();
    checks += 4;
    if (to_cnt - base_to != 1) begin errors++; $display("FAIL to_pulses got %0d exp 1", to_cnt - base_to); end
    if (to_cyc - dv_cyc != TO) begin errors++; $display("FAIL to_delay got %0d exp %0d", to_cyc - dv_cyc, TO); end
    if (to_busy !== 1'b0) begin errors++; $display("FAIL to_busy_drop got %b exp 0", to_busy); end
    if (rx_q.size() != base_rx) begin errors++; $display("FAIL to_rx got %0d frames exp 0", rx_q.size() - base_rx); end
    suppress_done = 1'b0;
  endtask

  task automatic test_done_priority();
    int base_to = to_cnt;
    manual    = 1'b1;
    req_byte[23:16] = 8'h6C;
    req_valid = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_dv) break;
    end
    repeat (TO - 1) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL prio_pre_busy got %b exp 1", busy); end
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    checks += 2;
    if (timeout !== 1'b0) begin errors++; $display("FAIL prio_timeout got %b exp 0", timeout); end
    if (busy !== 1'b0) begin errors++; $display("FAIL prio_busy got %b exp 0", busy); end
    repeat (2) tick();
    checks++;
    if (to_cnt != base_to) begin errors++; $display("FAIL prio_to_cnt got %0d exp 0", to_cnt - base_to); end
  endtask

  task automatic test_done_ignored();
    req_byte[15:8] = 8'h42;
    req_valid = 4'b0010;
    tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    repeat (2) tick();
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy got %b exp 1", busy); end
    if (timeout !== 1'b0) begin errors++; $display("FAIL ign_timeout got %b exp 0", timeout); end
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ign_done_busy got %b exp 0", busy); end
    manual = 1'b0;
    tick();
  endtask

  task automatic test_reset_midframe();
    int base_dv, base_rdy1;
    bit early = 1'b0;
    bit ok;
    req_byte  = {8'h00, 8'h00, 8'h77, 8'h11};
    req_valid = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_dv) break;
    end
    repeat (500) tick();
    req_valid[1] = 1'b1;
    repeat (100) tick();
    rst_n = 1'b0;
    #1;
    checks += 6;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
    if (tx_dv !== 1'b0) begin errors++; $display("FAIL mid_dv got %b exp 0", tx_dv); end
    if (req_ready !== 4'b0) begin errors++; $display("FAIL mid_ready got %b exp 0000", req_ready); end
    if (tx_byte !== 8'h00) begin errors++; $display("FAIL mid_byte got %h exp 00", tx_byte); end
    if (grant_id !== 2'd0) begin errors++; $display("FAIL mid_grant got %0d exp 0", grant_id); end
    if (timeout !== 1'b0) begin errors++; $display("FAIL mid_timeout got %b exp 0", timeout); end
    tick();
    tick();
    rst_n = 1'b1;
    base_dv   = dv_cnt;
    base_rdy1 = ready_cnt[1];
    for (int i = 0; i < FRAME && mdl_active; i++) begin
      tick();
      if (busy) early = 1'b1;
    end
    checks += 2;
    if (early || dv_cnt != base_dv)
      begin errors++; $display("FAIL mid_deferred got %0d launches exp 0", dv_cnt - base_dv); end
    if (mdl_active) begin errors++; $display("FAIL mid_active_wait got %b exp 0", mdl_active); end
    wait_quiet(FRAME + 50, ok);
    checks += 3;
    if (!ok || grant_q.size() == 0 || grant_q[grant_q.size()-1] !== 2'd1)
      begin errors++; $display("FAIL mid_relaunch_grant got busy %b exp grant 1", busy); end
    if (rx_q.size() == 0 || rx_q[rx_q.size()-1] !== 8'h77)
      begin errors++; $display("FAIL mid_rx got %0d frames exp last 77", rx_q.size()); end
    if (ready_cnt[1] - base_rdy1 != 1)
      begin errors++; $display("FAIL mid_ready1 got %0d exp 1", ready_cnt[1] - base_rdy1); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_two_sticky();
    test_timeout();
    test_done_priority();
    test_done_ignored();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no completion exp finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte requesters sharing one UART transmitter.
REQ-002 Parameter CLKS_PER_BIT, default 217, clocks per UART bit; matches the attached transmitter.
REQ-003 Parameter TIMEOUT_CLKS, default 12*CLKS_PER_BIT, maximum clocks to wait for transmit completion.
REQ-004 i_clk  input  1  system clock; all logic on rising edge.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_req_valid  input  NUM_REQ  per-requester byte-pending flag, held until accepted.
REQ-007 i_req_byte  input  8*NUM_REQ  per-requester byte; slice k is bits [8k+7:8k].
REQ-008 o_req_ready  output  NUM_REQ  one-cycle accept pulse, at most one bit set.
REQ-009 o_tx_dv  output  1  one-cycle launch strobe to transmitter data-valid input.
REQ-010 o_tx_byte  output  8  byte to transmitter, stable from the o_tx_dv cycle until completion.
REQ-011 i_tx_active  input  1  transmitter busy status.
REQ-012 i_tx_done  input  1  transmitter one-cycle completion pulse.
REQ-013 o_grant_id  output  clog2(NUM_REQ)  index of the requester currently owning the line.
REQ-014 o_busy  output  1  high in every state except IDLE.
REQ-015 o_timeout  output  1  one-cycle pulse when completion wait expires.

Function
REQ-016 The FSM SHALL have states IDLE, LAUNCH, WAIT_DONE, with all outputs registered.
REQ-017 IDLE -> LAUNCH when any i_req_valid bit is high and i_tx_active is low; otherwise stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: the winner is the first valid index at or after rr_ptr, wrapping NUM_REQ-1 to 0.
REQ-019 On the IDLE->LAUNCH transition, the block SHALL latch the winner's byte into o_tx_byte and its index into o_grant_id.
REQ-020 In LAUNCH, for exactly one cycle, the block SHALL assert o_tx_dv and o_req_ready[o_grant_id], set rr_ptr to o_grant_id+1 (mod NUM_REQ), and go to WAIT_DONE.
REQ-021 Latency: a valid request sampled in IDLE SHALL produce o_tx_dv and o_req_ready two clock edges later.
REQ-022 WAIT_DONE -> IDLE on i_tx_done; the next arbitration SHALL occur no earlier than the following cycle.
REQ-023 A 16-bit-minimum wait counter SHALL clear on entry to WAIT_DONE and increment each cycle there; on reaching TIMEOUT_CLKS-1 without i_tx_done, the FSM SHALL pulse o_timeout and return to IDLE.
REQ-024 If i_tx_done and the timeout terminal count coincide, done SHALL take priority and o_timeout SHALL stay low.
REQ-025 Requests dropping before acceptance SHALL be ignored; a winner is fixed once latched.
REQ-026 i_tx_done outside WAIT_DONE SHALL be ignored.
REQ-027 A requester SHALL receive at most one grant per NUM_REQ consecutive grants while other requesters remain valid.

Reset
REQ-028 While i_rst_n is low: state=IDLE, rr_ptr=0, counter=0, o_tx_dv=0, o_req_ready=0, o_tx_byte=8'h00, o_grant_id=0, o_busy=0, o_timeout=0.
REQ-029 After reset mid-frame, no launch SHALL occur until i_tx_active is sampled low.

Structure
REQ-030 The state encoding, the default CLKS_PER_BIT and the TIMEOUT_CLKS default SHALL reside in shared package uart_pkg.
REQ-031 The round-robin pick SHALL be a combinational sub-module rr_pick (inputs: request vector, pointer; outputs: winner index, any-valid).

Verification (bench: arbiter driving UART_TX, looped into UART_RX, CLKS_PER_BIT=217)
REQ-032 Requester 0 requests 8'h3F alone -> one o_req_ready[0] pulse, one o_tx_dv pulse with o_tx_byte=8'h3F, and UART_RX reports 8'h3F.
REQ-033 All four requesters assert simultaneously with 8'hA1,8'hB2,8'hC3,8'hD4 at rr_ptr=0 -> UART_RX receives A1,B2,C3,D4 in that order and each ready pulses exactly once.
REQ-034 Requesters 0 and 2 are held permanently valid -> grant sequence is 0,2,0,2 across four frames.
REQ-035 i_tx_done is forced low with TIMEOUT_CLKS=4000 -> o_timeout pulses exactly 4000 cycles after o_tx_dv, then o_busy drops.
REQ-036 i_rst_n is pulsed low mid-frame while requester 1 is pending -> all outputs go to reset values, and relaunch is deferred until i_tx_active falls.
